// File: rtl/pc_link_if.sv
// Bus between EXE-stage branch resolution and the PC/link-stack unit.
// There is no valid/ready handshake: stall is the only flow control, and every unstalled edge consumes op.
interface pc_link_if #(
   parameter int AW    = 8,
   parameter int DEPTH = 4
);
   localparam int DW = $clog2(DEPTH + 1);

   logic          stall;
   logic [3:0]    op;
   logic          brx;
   logic [1:0]    zn;
   logic [AW-1:0] target;
   logic          err_clr;

   logic [AW-1:0] pc;
   logic          flush;
   logic [AW-1:0] link_top;
   logic [DW-1:0] depth;
   logic          full;
   logic          empty;
   logic          ovf_err;
   logic          unf_err;

   modport master (
      output stall, op, brx, zn, target, err_clr,
      input  pc, flush, link_top, depth, full, empty, ovf_err, unf_err
   );

   modport slave (
      input  stall, op, brx, zn, target, err_clr,
      output pc, flush, link_top, depth, full, empty, ovf_err, unf_err
   );
endinterface

// File: rtl/pc_link_unit.sv
// Program counter with a hardware return-address (link) stack; state updates on negedge clk.
// Define RAS_WRAP_EN to make a call on a full stack overwrite the oldest link instead of flagging overflow.
module pc_link_unit #(
   parameter int            AW       = 8,
   parameter int            DEPTH    = 4,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic     clk,
   input  logic     rst,
   pc_link_if.slave bus
);
   localparam int DW  = $clog2(DEPTH + 1);
   localparam int SPW = $clog2(DEPTH);

   localparam logic [3:0] OP_BR  = 4'h9;
   localparam logic [3:0] OP_BRC = 4'ha;
   localparam logic [3:0] OP_SUB = 4'hb;
   localparam logic [3:0] OP_RET = 4'hc;

   logic [AW-1:0]  pc_q, pc_d;
   logic           flush_q, flush_d;
   logic [SPW-1:0] sp_q, sp_d;
   logic [DW-1:0]  depth_q, depth_d;
   logic           ovf_q, ovf_d;
   logic           unf_q, unf_d;
   logic [AW-1:0]  stack_q [DEPTH];

   logic [AW-1:0]  seq;
   logic [SPW-1:0] sp_inc, sp_dec;
   logic           full_w, empty_w, taken;
   logic [AW-1:0]  link_top_w;
   logic           push_en, ovf_set, unf_set;

   assign seq        = pc_q + AW'(1);
   // The pointer wraps mod DEPTH explicitly so non-power-of-two depths still work.
   assign sp_inc     = (sp_q == SPW'(DEPTH - 1)) ? '0 : sp_q + SPW'(1);
   assign sp_dec     = (sp_q == '0) ? SPW'(DEPTH - 1) : sp_q - SPW'(1);
   assign full_w     = (depth_q == DW'(DEPTH));
   assign empty_w    = (depth_q == '0);
   assign link_top_w = empty_w ? '0 : stack_q[sp_dec];
   assign taken      = bus.brx ? bus.zn[0] : bus.zn[1];

   always_comb begin
      pc_d    = pc_q;
      flush_d = 1'b0;
      sp_d    = sp_q;
      depth_d = depth_q;
      push_en = 1'b0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      if (!bus.stall) begin
         pc_d = seq;
         case (bus.op)
            OP_RET: begin
               if (!empty_w) begin
                  pc_d    = link_top_w;
                  sp_d    = sp_dec;
                  depth_d = depth_q - DW'(1);
                  flush_d = 1'b1;
               end else begin
                  unf_set = 1'b1;
               end
            end
            OP_SUB: begin
               pc_d    = bus.target;
               flush_d = 1'b1;
               if (!full_w) begin
                  push_en = 1'b1;
                  sp_d    = sp_inc;
                  depth_d = depth_q + DW'(1);
               end else begin
`ifdef RAS_WRAP_EN
                  push_en = 1'b1;
                  sp_d    = sp_inc;
`else
                  ovf_set = 1'b1;
`endif
               end
            end
            OP_BR: begin
               pc_d    = bus.target;
               flush_d = 1'b1;
            end
            OP_BRC: begin
               if (taken) begin
                  pc_d    = bus.target;
                  flush_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
      // A set on the same edge as a clear wins.
      ovf_d = ovf_set | (ovf_q & ~bus.err_clr);
      unf_d = unf_set | (unf_q & ~bus.err_clr);
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         flush_q <= 1'b0;
         sp_q    <= '0;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      end else begin
         pc_q    <= pc_d;
         flush_q <= flush_d;
         sp_q    <= sp_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         if (push_en) stack_q[sp_q] <= seq;
      end
   end

   assign bus.pc       = pc_q;
   assign bus.flush    = flush_q;
   assign bus.link_top = link_top_w;
   assign bus.depth    = depth_q;
   assign bus.full     = full_w;
   assign bus.empty    = empty_w;
   assign bus.ovf_err  = ovf_q;
   assign bus.unf_err  = unf_q;
endmodule
